// File: rtl/ttt_turn_scheduler_if.sv
// Handshake and status bundle between the move sources and the tic-tac-toe turn scheduler.
// Latency: none, wires only.
// Backpressure: p_ready/c_ready gate which side's move request is observed.
interface ttt_turn_scheduler_if;
    logic              start;
    logic              p_valid;
    logic [3:0]        p_pos;
    logic              p_ready;
    logic              c_valid;
    logic [3:0]        c_pos;
    logic              c_ready;
    logic              move_err;
    logic [1:0]        err_code;
    logic [17:0]       board;
    logic [3:0]        move_cnt;
    logic              busy;
    logic              game_over;
    logic [1:0]        winner;
    logic              timeout_flag;

    // Move sources and game control drive the requests and observe status.
    modport master (
        output start, p_valid, p_pos, c_valid, c_pos,
        input  p_ready, c_ready, move_err, err_code, board, move_cnt,
               busy, game_over, winner, timeout_flag
    );

    // The scheduler consumes requests and owns all status.
    modport slave (
        input  start, p_valid, p_pos, c_valid, c_pos,
        output p_ready, c_ready, move_err, err_code, board, move_cnt,
               busy, game_over, winner, timeout_flag
    );
endinterface

// File: rtl/ttt_turn_scheduler.sv
// Owns the 3x3 board, alternates turns between player (O) and computer (X), validates and commits moves, detects win/draw/timeout.
// Latency: accepted move visible after the accepting edge; win/draw or next side's ready one edge later (CHECK cycle).
// Backpressure: only the side holding the turn sees ready; the other side's valid is ignored without error.
module ttt_turn_scheduler #(
    parameter int unsigned TURN_TIMEOUT    = 0,
    parameter bit          ALTERNATE_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    ttt_turn_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        P_TURN = 3'd1,
        C_TURN = 3'd2,
        CHECK  = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam logic [1:0] CODE_P = 2'b01;
    localparam logic [1:0] CODE_C = 2'b10;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_OCCUPIED = 2'b10;

    // Timer only needs to reach TURN_TIMEOUT-1; keep at least one bit when disabled.
    localparam int TW = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TURN_TIMEOUT > 0) ? TW'(TURN_TIMEOUT - 1) : '0;

    state_t          state;
    logic [8:0][1:0] cells;
    logic [3:0]      move_cnt;
    logic [TW-1:0]   timer;
    logic            first_c;     // 1: computer moves first in the next game
    logic            last_c;      // 1: the move under CHECK was the computer's
    logic            move_err;
    logic [1:0]      err_code;
    logic [1:0]      winner;
    logic            timeout_flag;

    logic            off_vld;
    logic [3:0]      off_pos;
    logic [1:0]      my_code;
    logic            pos_ok;
    logic [3:0]      cell_idx;
    logic            cell_free;
    logic            accept;
    logic [1:0]      last_code;

    // True when all three cells of any row, column or diagonal hold code c.
    function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] c);
        has_line = (b[0] == c && b[1] == c && b[2] == c) ||
                   (b[3] == c && b[4] == c && b[5] == c) ||
                   (b[6] == c && b[7] == c && b[8] == c) ||
                   (b[0] == c && b[3] == c && b[6] == c) ||
                   (b[1] == c && b[4] == c && b[7] == c) ||
                   (b[2] == c && b[5] == c && b[8] == c) ||
                   (b[0] == c && b[4] == c && b[8] == c) ||
                   (b[2] == c && b[4] == c && b[6] == c);
    endfunction

    // Select the offer of whichever side holds the turn and classify it.
    always_comb begin
        off_vld   = 1'b0;
        off_pos   = bus.p_pos;
        my_code   = CODE_P;
        if (state == P_TURN) begin
            off_vld = bus.p_valid;
        end else if (state == C_TURN) begin
            off_vld = bus.c_valid;
            off_pos = bus.c_pos;
            my_code = CODE_C;
        end
        pos_ok    = (off_pos >= 4'd1) && (off_pos <= 4'd9);
        cell_idx  = pos_ok ? (off_pos - 4'd1) : 4'd0;
        cell_free = (cells[cell_idx] == 2'b00);
        accept    = off_vld && pos_ok && cell_free;
        last_code = last_c ? CODE_C : CODE_P;
    end

    // Game sequencer: turn handshake, commit, timeout and end-of-game evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cells        <= '0;
            move_cnt     <= '0;
            timer        <= '0;
            first_c      <= 1'b0;
            last_c       <= 1'b0;
            move_err     <= 1'b0;
            err_code     <= 2'b00;
            winner       <= 2'b00;
            timeout_flag <= 1'b0;
        end else begin
            move_err <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (bus.start) begin
                        cells        <= '0;
                        move_cnt     <= '0;
                        winner       <= 2'b00;
                        timeout_flag <= 1'b0;
                        timer        <= '0;
                        state        <= first_c ? C_TURN : P_TURN;
                        if (ALTERNATE_FIRST) begin
                            first_c <= ~first_c;
                        end
                    end
                end
                P_TURN, C_TURN: begin
                    if (accept) begin
                        // A legal move wins over a timeout on the same edge.
                        cells[cell_idx] <= my_code;
                        move_cnt        <= move_cnt + 4'd1;
                        timer           <= '0;
                        last_c          <= (state == C_TURN);
                        state           <= CHECK;
                    end else begin
                        if (off_vld) begin
                            move_err <= 1'b1;
                            err_code <= pos_ok ? ERR_OCCUPIED : ERR_RANGE;
                        end
                        if ((TURN_TIMEOUT > 0) && (timer == TIMER_LAST)) begin
                            state        <= OVER;
                            timeout_flag <= 1'b1;
                            winner       <= (state == P_TURN) ? CODE_C : CODE_P;
                            timer        <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (has_line(cells, last_code)) begin
                        state  <= OVER;
                        winner <= last_code;
                    end else if (move_cnt == 4'd9) begin
                        state  <= OVER;
                        winner <= 2'b00;
                    end else begin
                        state <= last_c ? P_TURN : C_TURN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status is decoded straight from registered state, so it is glitch-free.
    assign bus.p_ready      = (state == P_TURN);
    assign bus.c_ready      = (state == C_TURN);
    assign bus.busy         = (state == P_TURN) || (state == C_TURN) || (state == CHECK);
    assign bus.game_over    = (state == OVER);
    assign bus.move_err     = move_err;
    assign bus.err_code     = err_code;
    assign bus.board        = cells;
    assign bus.move_cnt     = move_cnt;
    assign bus.winner       = winner;
    assign bus.timeout_flag = timeout_flag;

endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// Directed bench: instance A (no timeout, alternating first mover) plays win/draw/error/reset scenarios;
// instance B (TURN_TIMEOUT=8, player always first) exercises the per-turn timeout.
// Inputs are driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_ttt_turn_scheduler;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    logic [17:0] exp_board;

    ttt_turn_scheduler_if ifa ();
    ttt_turn_scheduler_if ifb ();

    ttt_turn_scheduler #(.TURN_TIMEOUT(0), .ALTERNATE_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    ttt_turn_scheduler #(.TURN_TIMEOUT(8), .ALTERNATE_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) ifb.start = 1'b1; else ifa.start = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    // Present one move for one edge on the chosen instance.
    task automatic offer(input bit sel, input bit is_c, input logic [3:0] pos);
        @(negedge clk);
        if (sel) begin
            if (is_c) begin ifb.c_valid = 1'b1; ifb.c_pos = pos; end
            else      begin ifb.p_valid = 1'b1; ifb.p_pos = pos; end
        end else begin
            if (is_c) begin ifa.c_valid = 1'b1; ifa.c_pos = pos; end
            else      begin ifa.p_valid = 1'b1; ifa.p_pos = pos; end
        end
        @(posedge clk);
        #1;
        ifa.p_valid = 1'b0; ifa.c_valid = 1'b0;
        ifb.p_valid = 1'b0; ifb.c_valid = 1'b0;
    endtask

    // Expected board after a legal move.
    task automatic put(input bit is_c, input int pos);
        exp_board[2*(pos-1) +: 2] = is_c ? 2'b10 : 2'b01;
    endtask

    initial begin
        int draw_seq [9];
        bit side_c;
        draw_seq = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.p_valid = 1'b0; ifa.p_pos = 4'd0; ifa.c_valid = 1'b0; ifa.c_pos = 4'd0;
        ifb.start = 1'b0; ifb.p_valid = 1'b0; ifb.p_pos = 4'd0; ifb.c_valid = 1'b0; ifb.c_pos = 4'd0;
        #12;
        chk("rst_board",    ifa.board, 0);
        chk("rst_cnt",      ifa.move_cnt, 0);
        chk("rst_ready",    {ifa.p_ready, ifa.c_ready, ifa.busy, ifa.game_over}, 0);
        chk("rst_status",   {ifa.move_err, ifa.err_code, ifa.winner, ifa.timeout_flag}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Instance B: timeout scenarios ----
        pulse_start(1'b1);
        chk("b_first_p", {ifb.p_ready, ifb.c_ready}, 2'b10);
        @(negedge clk);
        ifb.c_valid = 1'b1; ifb.c_pos = 4'd5;   // off-turn request, must be ignored
        for (int i = 0; i < 7; i++) step();
        chk("b_to_not_yet",  ifb.game_over, 0);
        chk("b_offturn_err", ifb.move_err, 0);
        chk("b_offturn_brd", ifb.board, 0);
        chk("b_still_p",     ifb.p_ready, 1);
        step();
        ifb.c_valid = 1'b0;
        chk("b_to_over",   ifb.game_over, 1);
        chk("b_to_flag",   ifb.timeout_flag, 1);
        chk("b_to_winner", ifb.winner, 2'b10);
        chk("b_to_cnt",    ifb.move_cnt, 0);

        pulse_start(1'b1);
        chk("b2_first_p", {ifb.p_ready, ifb.timeout_flag, ifb.game_over}, 3'b100);
        for (int i = 0; i < 5; i++) step();
        offer(1'b1, 1'b0, 4'd5);
        chk("b2_board", ifb.board, 18'h00100);
        step();
        chk("b2_c_turn", ifb.c_ready, 1);
        for (int i = 0; i < 7; i++) step();
        chk("b2_c_hold", {ifb.c_ready, ifb.game_over}, 2'b10);
        step();
        chk("b2_to_over",   {ifb.game_over, ifb.timeout_flag}, 2'b11);
        chk("b2_to_winner", ifb.winner, 2'b01);

        pulse_start(1'b1);
        for (int i = 0; i < 7; i++) step();
        offer(1'b1, 1'b0, 4'd1);            // lands on the timeout edge
        chk("b3_prio_cnt",  ifb.move_cnt, 1);
        chk("b3_prio_over", {ifb.game_over, ifb.timeout_flag}, 2'b00);
        step();
        chk("b3_next_c", {ifb.c_ready, ifb.game_over}, 2'b10);

        // ---- Instance A game 1: errors and a player win ----
        exp_board = '0;
        pulse_start(1'b0);
        chk("a1_first_p", {ifa.p_ready, ifa.c_ready, ifa.busy}, 3'b101);
        offer(1'b0, 1'b1, 4'd5);
        chk("a1_offturn", {ifa.move_err, ifa.p_ready}, 2'b01);
        offer(1'b0, 1'b0, 4'd10);
        chk("a1_err10",   {ifa.move_err, ifa.err_code, ifa.p_ready}, 4'b1011);
        step();
        chk("a1_err_pulse", ifa.move_err, 0);
        offer(1'b0, 1'b0, 4'd0);
        chk("a1_err0",    {ifa.move_err, ifa.err_code, ifa.p_ready}, 4'b1011);
        chk("a1_err_brd", ifa.board, 0);
        pulse_start(1'b0);
        chk("a1_start_ign", {ifa.p_ready, ifa.busy, ifa.move_cnt}, 6'b110000);
        offer(1'b0, 1'b0, 4'd1); put(0, 1);
        chk("a1_m1_brd", ifa.board, exp_board);
        chk("a1_m1_chk", {ifa.p_ready, ifa.c_ready, ifa.busy, ifa.move_cnt}, 7'b0010001);
        step();
        chk("a1_c_turn", ifa.c_ready, 1);
        offer(1'b0, 1'b1, 4'd4); put(1, 4); step();
        offer(1'b0, 1'b0, 4'd2); put(0, 2); step();
        offer(1'b0, 1'b1, 4'd1);
        chk("a1_occ",     {ifa.move_err, ifa.err_code, ifa.c_ready}, 4'b1101);
        chk("a1_occ_brd", ifa.board, 18'h00085);
        offer(1'b0, 1'b1, 4'd5); put(1, 5); step();
        offer(1'b0, 1'b0, 4'd3); put(0, 3);
        chk("a1_m5_brd",  ifa.board, 18'h00295);
        chk("a1_m5_over", ifa.game_over, 0);
        step();
        chk("a1_win",     {ifa.game_over, ifa.winner, ifa.timeout_flag}, 4'b1010);
        chk("a1_win_cnt", ifa.move_cnt, 5);
        chk("a1_win_bsy", {ifa.busy, ifa.p_ready, ifa.c_ready}, 0);

        // ---- Instance A game 2: computer first, draw ----
        exp_board = '0;
        pulse_start(1'b0);
        chk("a2_first_c", {ifa.c_ready, ifa.p_ready}, 2'b10);
        chk("a2_cleared", {ifa.board, ifa.move_cnt, ifa.winner, ifa.game_over}, 0);
        side_c = 1'b1;
        for (int i = 0; i < 9; i++) begin
            offer(1'b0, side_c, 4'(draw_seq[i]));
            put(side_c, draw_seq[i]);
            chk("a2_brd", ifa.board, exp_board);
            step();
            side_c = ~side_c;
        end
        chk("a2_draw",     {ifa.game_over, ifa.winner}, 3'b100);
        chk("a2_draw_cnt", ifa.move_cnt, 9);
        chk("a2_draw_brd", ifa.board, 18'h295A6);

        // ---- Instance A game 3: reset mid-game ----
        pulse_start(1'b0);
        chk("a3_first_p", ifa.p_ready, 1);
        offer(1'b0, 1'b0, 4'd1); step();
        offer(1'b0, 1'b1, 4'd2); step();
        offer(1'b0, 1'b0, 4'd3); step();
        chk("a3_pre_rst", {ifa.move_cnt, ifa.c_ready}, 5'b00111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a3_rst_brd", ifa.board, 0);
        chk("a3_rst_cnt", ifa.move_cnt, 0);
        chk("a3_rst_rdy", {ifa.p_ready, ifa.c_ready, ifa.busy, ifa.game_over}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_turn_scheduler.md
Name: ttt_turn_scheduler

Overview:
- Synchronous sequencer that owns the 3x3 game board and shares it between two move requesters: player (O) and computer (X).
- Grants turns in strict alternation and validates each move. Commits legal moves to the board register and detects win or draw.
- Enforces an optional per-turn timeout. Sits between the move sources (keypad decoder, computer move generator) and the board display/status logic.

Parameters:
- TURN_TIMEOUT, 0, cycles a side may hold its turn without a legal move before forfeiting; 0 disables the timeout.
- ALTERNATE_FIRST, 1, when 1 the first mover toggles each new game; when 0 the player always moves first.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a new game from IDLE or OVER
- p_valid  input  1  player move request
- p_pos  input  4  player cell index, 1..9 row-major
- p_ready  output  1  player may present a move (player's turn)
- c_valid  input  1  computer move request
- c_pos  input  4  computer cell index, 1..9
- c_ready  output  1  computer may present a move
- move_err  output  1  one-cycle pulse: offered move rejected
- err_code  output  2  01 out of range, 10 cell occupied; holds last error
- board  output  18  cell k (0..8) at bits [2k+1:2k]; 00 empty, 01 player, 10 computer
- move_cnt  output  4  moves committed this game, 0..9
- busy  output  1  game in progress (P_TURN, C_TURN or CHECK)
- game_over  output  1  high in OVER
- winner  output  2  00 draw/none, 01 player, 10 computer; valid while game_over
- timeout_flag  output  1  game ended by turn timeout

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; board 0; move_cnt 0; turn timer 0; first-mover register = player.
  - All outputs 0; err_code 00.
- States: IDLE, P_TURN, C_TURN, CHECK, OVER. Registered, single always_ff next-state.
- IDLE / OVER, on start:
  - clear board, move_cnt, winner, timeout_flag, timer;
  - go to P_TURN or C_TURN per the first-mover register;
  - if ALTERNATE_FIRST=1, toggle first mover after use.
  - start is ignored in all other states.
- Readiness: p_ready = (state==P_TURN); c_ready = (state==C_TURN). A valid from the side not holding the turn is ignored and causes no error.
- Handshake in the turn state, when valid && ready at a rising edge:
  - pos in 1..9 and cell empty: write that side's code into cell pos-1, move_cnt+1, clear timer, go to CHECK.
  - pos 0 or >9: move_err=1 for one cycle, err_code=01, stay in turn, timer keeps counting.
  - cell occupied: move_err=1, err_code=10, stay in turn.
- Timer:
  - counts every cycle spent in P_TURN/C_TURN.
  - If TURN_TIMEOUT>0 and timer reaches TURN_TIMEOUT-1 with no accepted move: go to OVER, timeout_flag=1, winner = opposite side.
  - An accepted move on that same edge takes priority over the timeout.
- CHECK (exactly one cycle, operates on the committed board):
  - any of the 8 lines (3 rows, 3 cols, 2 diagonals) all equal to the last mover's code: OVER, winner = last mover;
  - else move_cnt==9: OVER, winner=00 (draw);
  - else go to the opposite side's turn state.
- Latency: move accepted at edge N -> board/move_cnt visible after N; winner/game_over or the next side's ready visible after edge N+1.
- OVER: board, move_cnt, winner and timeout_flag hold until start or reset.
- Reset mid-game: immediate return to reset values; no partial commit.

Test Plan:
- Reset, start; player 1, computer 4, player 2, computer 5, player 3 -> after the last CHECK: game_over=1, winner=01, move_cnt=5, board cells 0..2 = 01.
- Player offers pos 10, then pos 0 -> move_err pulses twice with err_code=01; board unchanged; p_ready stays 1. Player 5 accepted, then computer 5 -> move_err, err_code=10, c_ready stays 1.
- Fill the board with the sequence 1,2,3,5,4,6,8,7,9 (no line) -> after the 9th move's CHECK: game_over=1, winner=00, move_cnt=9.
- TURN_TIMEOUT=8, start, hold p_valid=0 -> game_over after 8 turn cycles, timeout_flag=1, winner=10. c_valid asserted during P_TURN -> no effect, no error.
- ALTERNATE_FIRST=1: game 1 starts in P_TURN; start from OVER -> c_ready=1 first and board cleared. start during a turn is ignored.
- Assert rst_n=0 mid-game after 3 moves -> board=0, move_cnt=0, p_ready=c_ready=0, state IDLE within the same cycle.
